// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then one inverse round per clock.
// Optional rk10 cache for repeated keys is enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] cipherText,
  input  logic [127:0] key,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] plainText
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  localparam logic [7:0] ISBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} fsm_e;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xt(input logic [7:0] x);
    return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d, key_q, key_d, plain_q, plain_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         hit;
  logic [127:0] hit_rk;

  // Key schedule: one shared 4-byte SubWord serves the forward and the inverse step.
  logic [31:0]  k0, k1, k2, k3, n0, n1, n2, n3, f0, f1, f2, f3, sb_in, sb_out;
  logic [127:0] fwd_key, inv_key, isr, isb, ark, imc;

  assign {k0, k1, k2, k3} = key_q;
  assign n3 = k3 ^ k2;
  assign n2 = k2 ^ k1;
  assign n1 = k1 ^ k0;
  assign sb_in = (fsm_q == DEC) ? {n3[23:0], n3[31:24]} : {k3[23:0], k3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sb
    assign sb_out[8*i +: 8] = SBOX[sb_in[8*i +: 8]];
  end

  assign n0 = k0 ^ sb_out ^ {rcon_q, 24'h0};
  assign f0 = n0;
  assign f1 = k1 ^ f0;
  assign f2 = k2 ^ f1;
  assign f3 = k3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};
  assign inv_key = {n0, n1, n2, n3};

  // Inverse round: row r of column c takes the byte from column c-r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4*c + r;
      localparam int SRC = 4*((c + 4 - r) % 4) + r;
      assign isr[127-8*DST -: 8] = state_q[127-8*SRC -: 8];
      assign isb[127-8*DST -: 8] = ISBOX[isr[127-8*DST -: 8]];
    end
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  assign ark = isb ^ inv_key;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] ck_key_q, ck_key_d, ck_rk_q, ck_rk_d;
  logic         ck_vld_q, ck_vld_d;

  assign hit    = ck_vld_q && (key == ck_key_q);
  assign hit_rk = ck_rk_q;

  always_comb begin
    ck_key_d = ck_key_q;
    ck_rk_d  = ck_rk_q;
    ck_vld_d = ck_vld_q;
    if (fsm_q == IDLE && inValid && !hit) begin
      ck_key_d = key;
      ck_vld_d = 1'b0;
    end
    if (fsm_q == KEXP && cnt_q == 4'd0) begin
      ck_rk_d  = fwd_key;
      ck_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_key_q <= '0;
      ck_rk_q  <= '0;
      ck_vld_q <= 1'b0;
    end else begin
      ck_key_q <= ck_key_d;
      ck_rk_q  <= ck_rk_d;
      ck_vld_q <= ck_vld_d;
    end
  end
`else
  assign hit    = 1'b0;
  assign hit_rk = '0;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    plain_d = plain_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      IDLE: if (inValid) begin
        cnt_d = 4'd9;
        if (hit) begin
          state_d = cipherText ^ hit_rk;
          key_d   = hit_rk;
          rcon_d  = 8'h36;
          fsm_d   = DEC;
        end else begin
          state_d = cipherText;
          key_d   = key;
          rcon_d  = 8'h01;
          fsm_d   = KEXP;
        end
      end
      KEXP: begin
        key_d = fwd_key;
        cnt_d = cnt_q - 4'd1;
        // rcon stays at 0x36: the first inverse step needs rcon_10
        if (cnt_q == 4'd0) begin
          state_d = state_q ^ fwd_key;
          cnt_d   = 4'd9;
          fsm_d   = DEC;
        end else begin
          rcon_d = xt(rcon_q);
        end
      end
      DEC: begin
        key_d  = inv_key;
        rcon_d = inv_xt(rcon_q);
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          plain_d = ark;
          fsm_d   = DONE;
        end else begin
          state_d = imc;
        end
      end
      DONE: if (outReady) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      plain_q <= '0;
      rcon_q  <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      plain_q <= plain_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inReady   = (fsm_q == IDLE);
  assign outValid  = (fsm_q == DONE);
  assign plainText = plain_q;
endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative AES-128 decryption engine: the inverse of the team's combinational AES-128 encryption top. It accepts a 128-bit ciphertext and the original cipher key over a valid/ready handshake. It derives the last round key by forward key expansion, then runs the FIPS-197 inverse cipher at one round per clock, regenerating round keys backwards on the fly. It sits downstream of the encryption datapath and recovers plaintext in a fraction of the area of an unrolled decryptor.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- inValid  input  1  request valid.
- inReady  output  1  engine idle and able to accept.
- cipherText  input  128  ciphertext; byte 0 = [127:120], column-major per FIPS-197.
- key  input  128  original cipher key (round key 0), same byte order.
- outValid  output  1  plainText valid.
- outReady  input  1  consumer accepts plainText.
- plainText  output  128  decrypted block.

## Operation
- States: IDLE, KEXP, DEC, DONE.
- IDLE: inReady=1. Accept on inValid&&inReady; latch cipherText; load key register with key; rcon=0x01; go to KEXP.
- KEXP, 10 cycles:
  - Each cycle advances the key register one forward-schedule step: RotWord, SubWord, rcon XOR, then chained word XORs.
  - rcon advances by xtime (0x01..0x36).
  - On the 10th step, the key register holds rk10 and state <= cipherText ^ rk10. Go to DEC with round counter=9.
- DEC, 10 cycles, counter 9 down to 0:
  - rk_r is derived from rk_{r+1} by the inverse schedule: w[i] = w[i+4] ^ w[i+3] for i=1..3, then w0 = w4 ^ SubWord(RotWord(w3)) ^ rcon_{r+1}. rcon steps backwards (0x36..0x01) via inverse xtime.
  - Each cycle: InvShiftRows, InvSubBytes, XOR rk_r, then InvMixColumns except when r=0.
  - After r=0, plainText <= state. Go to DONE.
- DONE: outValid=1, plainText held stable until outReady. On outValid&&outReady, go to IDLE.
- No backpressure inside KEXP or DEC. inValid is ignored outside IDLE.
- All GF(2^8) arithmetic uses the 0x11B polynomial. S-box and inverse S-box are combinational ROMs, 4 and 16 instances respectively.

## Timing
- Reset values: inReady=1, outValid=0, plainText=0, state IDLE, all internal registers 0, key cache invalid.
- rst asserted mid-operation aborts immediately to the reset values. No partial result is ever presented.
- Latency without cache hit: outValid rises 20 cycles after the accepting edge (10 KEXP + 10 DEC).
- inReady is low from the cycle after acceptance until the cycle after the output handshake. Throughput is one block per ≥21 cycles.
- outValid&&outReady on the same edge returns to IDLE. A new request can be accepted on the following edge; there is no same-cycle accept.
- If outReady is held low, DONE persists indefinitely with plainText unchanged.

## Configuration
- AES_DEC_KEY_CACHE_EN:
  - Defined: the engine keeps a 128-bit cached key, the cached rk10, and a valid bit. The valid bit is cleared by rst and set when KEXP completes.
  - On acceptance with key == cached key and the valid bit set, KEXP is skipped: state <= cipherText ^ cached rk10 on the accepting edge, and the engine enters DEC directly. outValid then rises 10 cycles after acceptance.
  - On a cache miss, behaviour is the normal 20-cycle path, and the cache is overwritten.
  - Undefined: no cache storage; every request takes 20 cycles.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipherText 69c4e0d86a7b0430d8cdb78070b4c55a -> plainText 00112233445566778899aabbccddeeff; outValid exactly 20 cycles after accept.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, cipherText 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold outReady=0 for 50 cycles after outValid -> plainText stable and inReady=0 throughout; a request presented during DONE is not accepted until the cycle after the handshake.
- Reset mid-DEC: assert rst at cycle 15 of the C.1 run -> outValid=0 and plainText=0 immediately; a re-issued C.1 request completes correctly in 20 cycles.
- With AES_DEC_KEY_CACHE_EN: C.1 back-to-back twice with the same key -> second result correct with latency 10. Then run B vector -> latency 20, correct result. After rst, C.1 -> latency 20.
- Round-trip: 100 random key/plaintext pairs through the encryption top, then this engine -> plainText equals the original plaintext every time.
